sram_oq_axis_drain: RTL and testbench



---
 rtl/sram_oq_pkg.sv | 35 +++
 rtl/axis_skid_buffer.sv | 50 +++++
 rtl/sram_oq_axis_drain.sv | 123 ++++++++++++
 tb/tb_sram_oq_axis_drain.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_oq_pkg.sv
// Shared types and FIFO word layout helpers for the output-queue drain.
// Word layout, MSB to LSB: {tlast, tuser, tstrb, tdata}.
package sram_oq_pkg;

  localparam logic [1:0] StateIdleEnc    = 2'd0;
  localparam logic [1:0] StateXferEnc    = 2'd1;
  localparam logic [1:0] StateDiscardEnc = 2'd2;

  typedef enum logic [1:0] {
    StIdle    = StateIdleEnc,
    StXfer    = StateXferEnc,
    StDiscard = StateDiscardEnc
  } state_e;

  function automatic int unsigned strb_width(int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned strb_lsb(int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned user_lsb(int unsigned data_w);
    return data_w + data_w / 8;
  endfunction

  function automatic int unsigned last_bit(int unsigned data_w, int unsigned user_w);
    return data_w + data_w / 8 + user_w;
  endfunction

  function automatic int unsigned fifo_width(int unsigned data_w, int unsigned user_w);
    return data_w + data_w / 8 + user_w + 1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry in-order skid buffer; entry 0 is always the presented head.
module axis_skid_buffer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic [1:0]       occ
);

  logic [Width-1:0] e0_q, e1_q;
  logic [1:0]       occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) e0_q <= din;
          else               e1_q <= din;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          e0_q  <= e1_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; new word lands behind whatever remains.
          if (occ_q == 2'd1) begin
            e0_q <= din;
          end else begin
            e0_q <= e1_q;
            e1_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = e0_q;
  assign occ  = occ_q;

endmodule

// File: rtl/sram_oq_axis_drain.sv
// Drains a fallthrough FIFO into an AXI4-Stream master, framing packets,
// holding new packets on pause and truncating packets longer than MAX_PKT_WORDS.
module sram_oq_axis_drain
  import sram_oq_pkg::*;
#(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned MAX_PKT_WORDS        = 64,
  parameter int unsigned FIFO_W = fifo_width(C_M_AXIS_DATA_WIDTH, C_M_AXIS_TUSER_WIDTH)
) (
  input  logic                                axi_aclk,
  input  logic                                axi_resetn,
  input  logic [FIFO_W-1:0]                   fifo_dout,
  input  logic                                fifo_empty,
  output logic                                fifo_rd_en,
  input  logic                                pause,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tlast,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [31:0]                         pkt_count,
  output logic                                oversize_err
);

  localparam int unsigned UW       = C_M_AXIS_TUSER_WIDTH;
  localparam int unsigned UserLsb  = user_lsb(C_M_AXIS_DATA_WIDTH);
  localparam int unsigned LastBit  = last_bit(C_M_AXIS_DATA_WIDTH, C_M_AXIS_TUSER_WIDTH);
  localparam logic [15:0] MaxWords = 16'(MAX_PKT_WORDS);

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            err_d, err_q;
  logic [31:0]     pkt_count_q;
  logic            rd_en, push, push_last;
  logic [UW-1:0]   push_user;
  logic [1:0]      occ;
  logic [FIFO_W-1:0] skid_din, skid_dout;
  logic            fifo_last;

  assign fifo_last = fifo_dout[LastBit];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    rd_en     = 1'b0;
    push      = 1'b0;
    push_last = fifo_last;
    push_user = fifo_dout[UserLsb +: UW];
    unique case (state_q)
      StIdle: begin
        rd_en = !fifo_empty && !pause && (occ != 2'd2);
        push  = rd_en;
        if (rd_en && !fifo_last) begin
          state_d = StXfer;
          cnt_d   = 16'd1;
        end
      end
      StXfer: begin
        rd_en     = !fifo_empty && (occ != 2'd2);
        push      = rd_en;
        push_user = '0;
        if (rd_en) begin
          cnt_d = cnt_q + 16'd1;
          if (fifo_last) begin
            state_d = StIdle;
            cnt_d   = 16'd0;
          end else if (cnt_q + 16'd1 == MaxWords) begin
            push_last = 1'b1;
            err_d     = 1'b1;
            state_d   = StDiscard;
          end
        end
      end
      StDiscard: begin
        rd_en = !fifo_empty;
        if (rd_en && fifo_last) begin
          state_d = StIdle;
          cnt_d   = 16'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q     <= StIdle;
      cnt_q       <= 16'd0;
      err_q       <= 1'b0;
      pkt_count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

  assign skid_din = {push_last, push_user, fifo_dout[UserLsb-1:0]};

  axis_skid_buffer #(
    .Width (FIFO_W)
  ) u_skid (
    .clk   (axi_aclk),
    .rst_n (axi_resetn),
    .push  (push),
    .din   (skid_din),
    .pop   (m_axis_tvalid && m_axis_tready),
    .dout  (skid_dout),
    .occ   (occ)
  );

  // Keep the pop strobe low while reset is held even if the FIFO reports data.
  assign fifo_rd_en    = rd_en && axi_resetn;
  assign m_axis_tvalid = (occ != 2'd0);
  assign {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = skid_dout;
  assign pkt_count     = pkt_count_q;
  assign oversize_err  = err_q;

endmodule

// File: tb/tb_sram_oq_axis_drain.sv
// Scoreboard bench: a queue models the fallthrough FIFO, expected beats are
// queued as packets are written and compared as the sink accepts them.
module tb_sram_oq_axis_drain;

  localparam int unsigned DW     = 32;
  localparam int unsigned SW     = DW / 8;
  localparam int unsigned UW     = 16;
  localparam int unsigned MaxPkt = 4;
  localparam int unsigned FW     = DW + SW + UW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          pause;
  logic [DW-1:0] tdata;
  logic [SW-1:0] tstrb;
  logic [UW-1:0] tuser;
  logic          tlast, tvalid, tready;
  logic [31:0]   pkt_count;
  logic          oversize_err;

  sram_oq_axis_drain #(
    .C_M_AXIS_DATA_WIDTH  (DW),
    .C_M_AXIS_TUSER_WIDTH (UW),
    .MAX_PKT_WORDS        (MaxPkt)
  ) dut (
    .axi_aclk      (clk),
    .axi_resetn    (rst_n),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .pause         (pause),
    .m_axis_tdata  (tdata),
    .m_axis_tstrb  (tstrb),
    .m_axis_tuser  (tuser),
    .m_axis_tlast  (tlast),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .pkt_count     (pkt_count),
    .oversize_err  (oversize_err)
  );

  always #5 clk = ~clk;

  logic [FW-1:0] fifo_q[$];
  logic [FW-1:0] exp_q[$];
  int total = 0, bad = 0;
  int cyc = 0, pops = 0, exp_pkts = 0, exp_err = 0, err_pulses = 0;
  int first_pop, first_valid, first_acc, last_acc;
  bit seen_occ2 = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic push_pkt(input int n);
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [UW-1:0] u;
    logic          l;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      s = SW'($urandom_range(1, (1 << SW) - 1));
      u = UW'($urandom_range(1, (1 << UW) - 1));
      l = (i == n - 1);
      fifo_q.push_back({l, u, s, d});
      if (i < int'(MaxPkt))
        exp_q.push_back({l || (i == int'(MaxPkt) - 1), (i == 0) ? u : '0, s, d});
    end
    exp_pkts++;
    if (n > int'(MaxPkt)) exp_err++;
    drive_fifo();
  endtask

  task automatic mark();
    first_pop = -1; first_valid = -1; first_acc = -1; last_acc = -1;
  endtask

  // One clock: observe at the falling edge, apply FIFO pops just after the rising edge.
  task automatic step();
    logic popped;
    @(negedge clk);
    cyc++;
    popped = fifo_rd_en;
    if (popped) begin
      pops++;
      if (first_pop < 0) first_pop = cyc;
    end
    if (tvalid && first_valid < 0) first_valid = cyc;
    if (dut.occ == 2'd2) begin
      seen_occ2 = 1'b1;
      check("rd_en_at_occ2", 64'(fifo_rd_en), 64'd0);
    end
    if (oversize_err) err_pulses++;
    if (tvalid && tready) begin
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      if (exp_q.size() == 0) check("extra_beat", 64'd1, 64'd0);
      else check("beat", 64'({tlast, tuser, tstrb, tdata}), 64'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
    if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  initial begin
    int p0;
    rst_n = 1'b0; pause = 1'b0; tready = 1'b0;
    drive_fifo();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_fields", 64'({tlast, tuser, tstrb, tdata}), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    check("rst_err", 64'(oversize_err), 64'd0);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three 4-beat packets streamed back-to-back.
    tready = 1'b1;
    mark();
    repeat (3) push_pkt(4);
    drain("b2b");
    check("b2b_latency", 64'(first_valid), 64'(first_pop + 1));
    check("b2b_span", 64'(last_acc - first_acc), 64'd11);
    check("b2b_pkt_count", 64'(pkt_count), 64'(exp_pkts));

    // Backpressure: tready 1,0,0,1 mid-packet fills the skid buffer.
    push_pkt(4);
    push_pkt(4);
    step(); step();
    tready = 1'b0;
    step(); step();
    tready = 1'b1;
    drain("bp");
    check("bp_occ2_seen", 64'(seen_occ2), 64'd1);
    check("bp_pkt_count", 64'(pkt_count), 64'(exp_pkts));

    // Pause raised after beat 2 pops: current packet finishes, next is held.
    push_pkt(4);
    push_pkt(2);
    p0 = pops;
    for (int i = 0; i < 50 && pops - p0 < 2; i++) step();
    pause = 1'b1;
    repeat (10) step();
    check("pause_held_words", 64'(fifo_q.size()), 64'd2);
    check("pause_beats_left", 64'(exp_q.size()), 64'd2);
    check("pause_rd_en", 64'(fifo_rd_en), 64'd0);
    pause = 1'b0;
    drain("pause");
    check("pause_pkt_count", 64'(pkt_count), 64'(exp_pkts));

    // Oversize 7-beat packet truncated to 4, then an intact 2-beat packet.
    push_pkt(7);
    push_pkt(2);
    drain("ovs");
    repeat (2) step();
    check("ovs_err_pulses", 64'(err_pulses), 64'(exp_err));
    check("ovs_pkt_count", 64'(pkt_count), 64'(exp_pkts));

    // Single-beat packets at one per cycle.
    mark();
    repeat (8) push_pkt(1);
    drain("single");
    check("single_span", 64'(last_acc - first_acc), 64'd7);
    check("single_pkt_count", 64'(pkt_count), 64'(exp_pkts));
    check("single_state_idle", 64'(dut.state_q), 64'd0);

    // Asynchronous reset with the skid buffer full mid-packet.
    push_pkt(4);
    tready = 1'b0;
    repeat (3) step();
    check("rst2_pre_occ", 64'(dut.occ), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst2_tvalid", 64'(tvalid), 64'd0);
    check("rst2_fields", 64'({tlast, tuser, tstrb, tdata}), 64'd0);
    check("rst2_pkt_count", 64'(pkt_count), 64'd0);
    fifo_q.delete();
    exp_q.delete();
    exp_pkts = 0;
    drive_fifo();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tready = 1'b1;
    mark();
    push_pkt(2);
    drain("rst2");
    check("rst2_pkt_count_after", 64'(pkt_count), 64'(exp_pkts));
    check("rst2_err_total", 64'(err_pulses), 64'(exp_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
